puf_resp_verifier: RTL and testbench

//  Verifier end of the CT-PUF serial response link. Accepts the 1-bit/cycle response stream

---
 rtl/puf_resp_verifier_pkg.sv | 19 +
 rtl/puf_resp_verifier_if.sv | 28 ++
 rtl/puf_resp_verifier_hd_accum.sv | 55 +++++
 rtl/puf_resp_verifier.sv | 119 +++++++++++
 tb/tb_puf_resp_verifier.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/puf_resp_verifier_pkg.sv
// Shared constants, FSM encoding and width helper for the PUF response verifier.
package puf_resp_verifier_pkg;

  // Response length; matches the PUF challenge register width.
  localparam int unsigned PUF_RESP_BITS = 48;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DECIDE  = 2'd2,
    ST_ABORT   = 2'd3
  } state_t;

  // Bits needed to count 0..bits mismatches without wrapping.
  function automatic int unsigned hd_width(input int unsigned bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/puf_resp_verifier_if.sv
// Request/response bundle between the authentication controller and the verifier.
//   master: drives start, golden, bit_in, bit_valid; observes the verdict signals
//   slave : the verifier itself
interface puf_resp_verifier_if #(
  parameter int unsigned RESP_BITS = 48,
  parameter int unsigned HD_W      = 6
);
  logic                 start;
  logic [RESP_BITS-1:0] golden;
  logic                 bit_in;
  logic                 bit_valid;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 timeout;
  logic [HD_W-1:0]      hd;
  logic [RESP_BITS-1:0] resp_word;

  modport master (
    output start, golden, bit_in, bit_valid,
    input  busy, done, pass, timeout, hd, resp_word
  );

  modport slave (
    input  start, golden, bit_in, bit_valid,
    output busy, done, pass, timeout, hd, resp_word
  );
endinterface

// File: rtl/puf_resp_verifier_hd_accum.sv
// Beat index and saturating Hamming-distance counter.
//   clk, reset_n : clock, async active-low reset
//   clear        : restart at beat 0 with hd=0 (accepted start)
//   beat         : a response bit is being accepted this cycle
//   bit_in       : the response bit
//   golden_q     : latched golden response
//   hd           : registered mismatch count
//   hd_nxt_c     : count including this cycle's beat (lets the verdict see the last bit)
//   last_c       : current beat is the final one
module puf_resp_verifier_hd_accum
  import puf_resp_verifier_pkg::*;
#(
  parameter int unsigned RESP_BITS = PUF_RESP_BITS,
  parameter int unsigned HD_W      = hd_width(PUF_RESP_BITS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 beat,
  input  logic                 bit_in,
  input  logic [RESP_BITS-1:0] golden_q,
  output logic [HD_W-1:0]      hd,
  output logic [HD_W-1:0]      hd_nxt_c,
  output logic                 last_c
);

  localparam int unsigned IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  logic [IDX_W-1:0] idx;
  logic             miss_c;

  // Compare the incoming bit against its golden position; saturate at all-ones.
  always_comb begin
    miss_c   = bit_in ^ golden_q[idx];
    hd_nxt_c = hd;
    if (miss_c && (hd != '1)) begin
      hd_nxt_c = hd + HD_W'(1);
    end
    last_c = (idx == IDX_W'(RESP_BITS - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
      hd  <= '0;
    end else if (clear) begin
      idx <= '0;
      hd  <= '0;
    end else if (beat) begin
      hd  <= hd_nxt_c;
      idx <= last_c ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/puf_resp_verifier.sv
// Verifier end of the CT-PUF serial response link: rebuilds the response word from a
// 1-bit stream and grades it against the enrolled golden by Hamming distance.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : start/golden/bit_in/bit_valid in; busy/done/pass/timeout/hd/resp_word out
module puf_resp_verifier
  import puf_resp_verifier_pkg::*;
#(
  parameter int unsigned RESP_BITS = PUF_RESP_BITS,
  parameter int unsigned HD_MAX    = 6,
  parameter int unsigned HD_W      = hd_width(PUF_RESP_BITS),
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  puf_resp_verifier_if.slave bus
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  state_t               state;
  logic [RESP_BITS-1:0] golden_q;
  logic [RESP_BITS-1:0] resp_word_q;
  logic [IDLE_W-1:0]    idle_cnt;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic                 timeout_q;
  logic [HD_W-1:0]      hd_q;
  logic [HD_W-1:0]      hd_nxt_c;
  logic                 last_c;
  logic                 start_acc_c;
  logic                 beat_c;

  // Starts count only in IDLE; beats only while collecting.
  assign start_acc_c = (state == ST_IDLE) && bus.start;
  assign beat_c      = (state == ST_COLLECT) && bus.bit_valid;

  puf_resp_verifier_hd_accum #(
    .RESP_BITS (RESP_BITS),
    .HD_W      (HD_W)
  ) u_hd_accum (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (start_acc_c),
    .beat     (beat_c),
    .bit_in   (bus.bit_in),
    .golden_q (golden_q),
    .hd       (hd_q),
    .hd_nxt_c (hd_nxt_c),
    .last_c   (last_c)
  );

  // FSM, idle timer and response shift register. The verdict is registered on the
  // edge that accepts the last beat so done/pass are valid together in DECIDE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      golden_q    <= '0;
      resp_word_q <= '0;
      idle_cnt    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state       <= ST_COLLECT;
            golden_q    <= bus.golden;
            resp_word_q <= '0;
            idle_cnt    <= '0;
            busy_q      <= 1'b1;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (bus.bit_valid) begin
            resp_word_q <= {bus.bit_in, resp_word_q[RESP_BITS-1:1]};
            idle_cnt    <= '0;
            if (last_c) begin
              state  <= ST_DECIDE;
              done_q <= 1'b1;
              pass_q <= (32'(hd_nxt_c) <= HD_MAX);
            end
          end else if (idle_cnt == IDLE_W'(TIMEOUT)) begin
            state     <= ST_ABORT;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        ST_DECIDE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        ST_ABORT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.timeout   = timeout_q;
  assign bus.hd        = hd_q;
  assign bus.resp_word = resp_word_q;

endmodule

// File: tb/tb_puf_resp_verifier.sv
// Self-checking bench for puf_resp_verifier: vector table for full runs plus
// hand-written timeout, restart, back-to-back and mid-run reset sequences.
module tb_puf_resp_verifier;

  logic clk;
  logic reset_n;

  puf_resp_verifier_if #(.RESP_BITS(48), .HD_W(6)) bus ();
  puf_resp_verifier_if #(.RESP_BITS(48), .HD_W(4)) bus4 ();

  assign bus4.start     = bus.start;
  assign bus4.golden    = bus.golden;
  assign bus4.bit_in    = bus.bit_in;
  assign bus4.bit_valid = bus.bit_valid;

  puf_resp_verifier #(.RESP_BITS(48), .HD_MAX(6), .HD_W(6), .TIMEOUT(1023)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  puf_resp_verifier #(.RESP_BITS(48), .HD_MAX(6), .HD_W(4), .TIMEOUT(1023)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pass;
    logic [5:0]  hd;
    logic [3:0]  hd4;
    logic        timeout;
    logic [47:0] rw;
  } exp_t;

  typedef struct {
    logic [47:0] golden;
    logic [47:0] stream;
    int          gap;
    logic        pass;
    logic [5:0]  hd;
    logic [3:0]  hd4;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [47:0] g);
    bus.start  = 1'b1;
    bus.golden = g;
    tick();
    bus.start  = 1'b0;
  endtask

  // Send beats 0..n-1 of s; optionally pulse a bogus start together with one beat.
  task automatic send_beats(input logic [47:0] s, input int gap, input int restart_at, input int n);
    for (int k = 0; k < n; k++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = s[k];
      if (k == restart_at) begin
        bus.start  = 1'b1;
        bus.golden = 48'h0;
      end
      tick();
      bus.bit_valid = 1'b0;
      bus.start     = 1'b0;
      if (k != n - 1) repeat (gap) tick();
    end
  endtask

  function automatic exp_t mk_exp(input vec_t v);
    exp_t e;
    e.pass    = v.pass;
    e.hd      = v.hd;
    e.hd4     = v.hd4;
    e.timeout = 1'b0;
    e.rw      = v.stream;
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no verdict");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pass", 64'(bus.pass), 64'(e.pass));
        chk("hd", 64'(bus.hd), 64'(e.hd));
        chk("timeout", 64'(bus.timeout), 64'(e.timeout));
        chk("resp_word", 64'(bus.resp_word), 64'(e.rw));
        chk("hd_w4", 64'(bus4.hd), 64'(e.hd4));
        chk("done_w4", 64'(bus4.done), 64'd1);
      end
    end
  end

  initial begin
    logic [47:0] g;
    exp_t        e;
    int          cnt;

    g = 48'hA5A5_0F0F_3C3C;
    vecs[0] = '{g,                  g,                         0, 1'b1, 6'd0,  4'd0};
    vecs[1] = '{g,                  g ^ 48'h8000_0002_0001,    0, 1'b1, 6'd3,  4'd3};
    vecs[2] = '{g,                  g ^ 48'h0000_0000_007F,    0, 1'b0, 6'd7,  4'd7};
    vecs[3] = '{g,                  g,                         2, 1'b1, 6'd0,  4'd0};
    vecs[4] = '{48'h0,              48'hFFFF_FFFF_FFFF,        0, 1'b0, 6'd48, 4'd15};
    vecs[5] = '{48'h1234_5678_9ABC, 48'h1234_5678_9A83,        0, 1'b1, 6'd6,  4'd6};

    bus.start     = 1'b0;
    bus.golden    = '0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    reset_n       = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_pass", 64'(bus.pass), 64'd0);
    chk("rst_timeout", 64'(bus.timeout), 64'd0);
    chk("rst_hd", 64'(bus.hd), 64'd0);
    chk("rst_resp_word", 64'(bus.resp_word), 64'd0);
    reset_n = 1'b1;
    tick();

    // bit_valid in IDLE must not disturb anything.
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    repeat (3) tick();
    bus.bit_valid = 1'b0;
    chk("idle_bits_busy", 64'(bus.busy), 64'd0);
    chk("idle_bits_resp", 64'(bus.resp_word), 64'd0);

    // Table of complete runs.
    for (int i = 0; i < 6; i++) begin
      sb.push_back(mk_exp(vecs[i]));
      do_start(vecs[i].golden);
      chk("busy_collect", 64'(bus.busy), 64'd1);
      send_beats(vecs[i].stream, vecs[i].gap, -1, 48);
      chk("done_latency", 64'(bus.done), 64'd1);
      chk("busy_decide", 64'(bus.busy), 64'd1);
      tick();
      chk("done_one_cycle", 64'(bus.done), 64'd0);
      chk("busy_idle", 64'(bus.busy), 64'd0);
    end

    // Timeout after beat 10; partial word holds golden[9:0] at the top.
    e = '{1'b0, 6'd0, 4'd0, 1'b1, 48'h0F00_0000_0000};
    sb.push_back(e);
    do_start(g);
    send_beats(g, 0, -1, 10);
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 1100) begin
      tick();
      cnt++;
    end
    chk("timeout_latency_in_range", 64'((cnt >= 1023) && (cnt <= 1025)), 64'd1);
    chk("busy_abort", 64'(bus.busy), 64'd0);
    tick();

    // Start mid-run is ignored, then a back-to-back start right after done.
    sb.push_back(mk_exp(vecs[0]));
    do_start(g);
    send_beats(g, 0, 19, 48);
    chk("done_after_ignored_start", 64'(bus.done), 64'd1);
    tick();
    sb.push_back(mk_exp(vecs[1]));
    do_start(g);
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    send_beats(vecs[1].stream, 0, -1, 48);
    chk("b2b_done", 64'(bus.done), 64'd1);
    tick();

    // Reset at beat 30: everything clears at once, no verdict.
    do_start(g);
    send_beats(g, 0, -1, 30);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_hd", 64'(bus.hd), 64'd0);
    chk("mid_rst_resp", 64'(bus.resp_word), 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    sb.push_back(mk_exp(vecs[2]));
    do_start(g);
    send_beats(vecs[2].stream, 0, -1, 48);
    chk("post_rst_done", 64'(bus.done), 64'd1);
    tick();

    cnt = 0;
    while (sb.size() != 0 && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
